// File: rtl/rasp_gpio_rx.sv
// Byte receiver for the Raspberry Pi GPIO link: synchronises the toggle-strobe bus,
// waits for the data pins to settle, buffers bytes in a FWFT FIFO and returns a toggle ack.
module rasp_gpio_rx #(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     lock,
    input  logic [7:0]               gpio_data_i,
    input  logic                     gpio_stb_i,
    output logic                     gpio_ack_o,
    output logic [7:0]               rx_data_o,
    output logic                     rx_valid_o,
    input  logic                     rx_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o,
    output logic                     err_o,
    input  logic                     clr_err_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, PUSH} state_t;

    logic [7:0]    data_s1, data_s2;
    logic          stb_s1, stb_s2, stb_q;
    logic          tog;
    logic [1:0]    arm_cnt;
    logic          armed;
    state_t        state, state_nxt;
    logic [CW-1:0] settle_cnt, settle_nxt;
    logic          wr_en, pop, full, err_set;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [7:0]    mem [DEPTH];

    assign tog        = stb_s2 ^ stb_q;
    assign armed      = (arm_cnt == 2'd3);
    assign rx_valid_o = (fifo_cnt != '0);
    assign full       = (fifo_cnt == (AW+1)'(DEPTH));
    assign pop        = rx_valid_o && rx_ready_i;
    assign err_set    = tog && armed && (state != IDLE);
    assign fifo_cnt_o = fifo_cnt;
    assign rx_data_o  = rx_valid_o ? mem[rd_ptr] : 8'h00;

    // Synchroniser stage: pins into clk, plus the delayed strobe for edge detection
    always_ff @(posedge clk or negedge lock) begin
        if (!lock) begin
            data_s1 <= '0;
            data_s2 <= '0;
            stb_s1  <= 1'b0;
            stb_s2  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            data_s1 <= gpio_data_i;
            data_s2 <= data_s1;
            stb_s1  <= gpio_stb_i;
            stb_s2  <= stb_s1;
            stb_q   <= stb_s2;
        end
    end

    // Arming adopts whatever strobe level the Pi holds at start-up as already acknowledged
    always_ff @(posedge clk or negedge lock) begin
        if (!lock) begin
            arm_cnt    <= '0;
            gpio_ack_o <= 1'b0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            if (!armed && arm_cnt == 2'd2) begin
                gpio_ack_o <= stb_s2;
            end else if (wr_en) begin
                gpio_ack_o <= stb_q;
            end
        end
    end

    always_ff @(posedge clk or negedge lock) begin
        if (!lock) begin
            state      <= IDLE;
            settle_cnt <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            if (err_set) begin
                err_o <= 1'b1;
            end else if (clr_err_i) begin
                err_o <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (tog && armed) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
            end
            SETTLE: begin
                settle_nxt = settle_cnt + 1'b1;
                if (settle_cnt == CW'(SETTLE_CYC - 1)) begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                // Holding here withholds the ack, which is the Pi's only backpressure
                if (!full || pop) begin
                    wr_en     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO stage: pointers and occupancy
    always_ff @(posedge clk or negedge lock) begin
        if (!lock) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_s2;
        end
    end

endmodule
